// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates ex/irq redirects, defers blocked ex jumps,
// and drives per-stage stall/flush vectors plus a sticky hold-timeout flag.
module pipe_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int NUM_STAGES   = 4,
  parameter int JUMP_STAGE   = 2,
  parameter int FLUSH_DEPTH  = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_en_i,
  input  logic [ADDR_W-1:0]     jump_addr_i,
  input  logic                  irq_jump_en_i,
  input  logic [ADDR_W-1:0]     irq_jump_addr_i,
  input  logic [NUM_STAGES-1:0] hold_req_i,
  output logic                  jump_en_o,
  output logic [ADDR_W-1:0]     jump_addr_o,
  output logic [NUM_STAGES-1:0] hold_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  hold_flag_o,
  output logic                  hold_timeout_o
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam int TW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);
  localparam logic [TW-1:0] TMAX       = TW'(HOLD_TIMEOUT);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_irq_q, pend_irq_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              jump_en_q, jump_en_d;
  logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              timeout_q, timeout_d;

  logic [NUM_STAGES-1:0] hold_any;
  logic                  flush_active;
  logic                  ex_block;
  logic                  cand_valid, cand_irq, blocked, accept;
  logic [ADDR_W-1:0]     cand_addr;

  assign flush_active = (fcnt_q != '0);
  assign ex_block     = |hold_req_i[NUM_STAGES-1:JUMP_STAGE];

  // A stage stalls whenever it or anything downstream of it stalls; flush overrides.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign hold_any[gi] = |hold_req_i[NUM_STAGES-1:gi];
      if (gi < FLUSH_DEPTH) begin : g_fl
        assign flush_o[gi] = flush_active;
      end else begin : g_nofl
        assign flush_o[gi] = 1'b0;
      end
      assign hold_o[gi] = hold_any[gi] & ~flush_o[gi];
    end
  endgenerate

  assign hold_flag_o    = (|hold_o) | (|flush_o);
  assign jump_en_o      = jump_en_q;
  assign jump_addr_o    = jump_addr_q;
  assign hold_timeout_o = timeout_q;

  always_comb begin
    cand_valid = pend_valid_q;
    cand_irq   = pend_irq_q;
    cand_addr  = pend_addr_q;
    if (irq_jump_en_i) begin
      cand_valid = 1'b1;
      cand_irq   = 1'b1;
      cand_addr  = irq_jump_addr_i;
    end else if (jump_en_i && !(pend_valid_q && pend_irq_q)) begin
      cand_valid = 1'b1;
      cand_irq   = 1'b0;
      cand_addr  = jump_addr_i;
    end
    blocked = cand_valid & ~cand_irq & ex_block;
    accept  = cand_valid & ~blocked;

    pend_valid_d = pend_valid_q;
    pend_irq_d   = pend_irq_q;
    pend_addr_d  = pend_addr_q;
    if (accept) begin
      pend_valid_d = 1'b0;
      pend_irq_d   = 1'b0;
    end else if (blocked) begin
      pend_valid_d = 1'b1;
      pend_irq_d   = cand_irq;
      pend_addr_d  = cand_addr;
    end

    jump_en_d   = accept;
    jump_addr_d = accept ? cand_addr : jump_addr_q;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (accept) begin
          fcnt_d = FLUSH_LOAD;
        end else if (fcnt_q <= CW'(1)) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  // Timeout only observes stalls; saturating count so the flag can never re-arm.
  always_comb begin
    tcnt_d = tcnt_q;
    if (!(|hold_o)) begin
      tcnt_d = '0;
    end else if (tcnt_q != TMAX) begin
      tcnt_d = tcnt_q + TW'(1);
    end
    timeout_d = timeout_q | ((HOLD_TIMEOUT != 0) && (tcnt_d == TMAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fcnt_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_irq_q   <= 1'b0;
      pend_addr_q  <= '0;
      jump_en_q    <= 1'b0;
      jump_addr_q  <= '0;
      tcnt_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      pend_valid_q <= pend_valid_d;
      pend_irq_q   <= pend_irq_d;
      pend_addr_q  <= pend_addr_d;
      jump_en_q    <= jump_en_d;
      jump_addr_q  <= jump_addr_d;
      tcnt_q       <= tcnt_d;
      timeout_q    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: instance a (FLUSH_CYCLES=1, HOLD_TIMEOUT=8) and
// instance b (FLUSH_CYCLES=3, HOLD_TIMEOUT=1024) share one stimulus stream.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        irq_jump_en_i;
  logic [31:0] irq_jump_addr_i;
  logic [3:0]  hold_req_i;

  logic        a_jen, b_jen;
  logic [31:0] a_addr, b_addr;
  logic [3:0]  a_hold, b_hold, a_flush, b_flush;
  logic        a_hflag, b_hflag, a_to, b_to;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.FLUSH_CYCLES(1), .HOLD_TIMEOUT(8)) u_a (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .irq_jump_en_i(irq_jump_en_i), .irq_jump_addr_i(irq_jump_addr_i),
    .hold_req_i(hold_req_i),
    .jump_en_o(a_jen), .jump_addr_o(a_addr), .hold_o(a_hold), .flush_o(a_flush),
    .hold_flag_o(a_hflag), .hold_timeout_o(a_to)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .irq_jump_en_i(irq_jump_en_i), .irq_jump_addr_i(irq_jump_addr_i),
    .hold_req_i(hold_req_i),
    .jump_en_o(b_jen), .jump_addr_o(b_addr), .hold_o(b_hold), .flush_o(b_flush),
    .hold_flag_o(b_hflag), .hold_timeout_o(b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0;
    irq_jump_en_i = 1'b0; irq_jump_addr_i = '0; hold_req_i = 4'b0101;
    #2;
    chk("rst_jen",   a_jen, 0);
    chk("rst_addr",  a_addr, 0);
    chk("rst_flush", b_flush, 0);
    chk("rst_to",    a_to, 0);
    chk("rst_hold",  a_hold, 4'b0111);
    chk("rst_hflag", a_hflag, 1);
    hold_req_i = 4'b0000;
    tick; tick;
    rst_n = 1'b1;
    tick; tick;

    // single ex jump, no holds
    jump_en_i = 1'b1; jump_addr_i = 32'h100;
    #1 chk("t1_pre_jen", a_jen, 0);
    tick; jump_en_i = 1'b0;
    chk("t1_a_jen",   a_jen, 1);
    chk("t1_a_addr",  a_addr, 32'h100);
    chk("t1_a_flush", a_flush, 4'b0011);
    chk("t1_a_hflag", a_hflag, 1);
    chk("t1_b_flush", b_flush, 4'b0011);
    tick;
    chk("t1_a_jen2",   a_jen, 0);
    chk("t1_a_flush2", a_flush, 0);
    chk("t1_a_hflag2", a_hflag, 0);
    chk("t1_b_flush2", b_flush, 4'b0011);
    chk("t1_b_jen2",   b_jen, 0);
    tick;
    chk("t1_b_flush3", b_flush, 4'b0011);
    tick;
    chk("t1_b_flush4", b_flush, 0);
    tick;

    // ex jump deferred by a downstream hold
    hold_req_i = 4'b1000; jump_en_i = 1'b1; jump_addr_i = 32'h200;
    #1 chk("t2_hold", a_hold, 4'b1111);
    chk("t2_flush", a_flush, 0);
    tick; jump_en_i = 1'b0;
    chk("t2_a_jen_c2", a_jen, 0);
    chk("t2_b_jen_c2", b_jen, 0);
    chk("t2_hold_c2",  a_hold, 4'b1111);
    tick;
    chk("t2_a_jen_c3", a_jen, 0);
    tick; hold_req_i = 4'b0000;
    #1 chk("t2_hold_rel", a_hold, 0);
    chk("t2_a_jen_c4", a_jen, 0);
    tick;
    chk("t2_a_jen_c5",  a_jen, 1);
    chk("t2_a_addr_c5", a_addr, 32'h200);
    chk("t2_b_jen_c5",  b_jen, 1);
    chk("t2_b_addr_c5", b_addr, 32'h200);
    tick;
    chk("t2_a_jen_c6", a_jen, 0);
    tick; tick; tick; tick;

    // irq and ex in the same cycle: irq wins, ex dropped
    irq_jump_en_i = 1'b1; irq_jump_addr_i = 32'h40;
    jump_en_i = 1'b1; jump_addr_i = 32'h80;
    tick; irq_jump_en_i = 1'b0; jump_en_i = 1'b0;
    chk("t3_a_jen",  a_jen, 1);
    chk("t3_a_addr", a_addr, 32'h40);
    chk("t3_b_addr", b_addr, 32'h40);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t3_a_nojen",  a_jen, 0);
      chk("t3_a_keep",   a_addr, 32'h40);
    end

    // irq is never blocked by a hold
    hold_req_i = 4'b1000; irq_jump_en_i = 1'b1; irq_jump_addr_i = 32'h44;
    tick; irq_jump_en_i = 1'b0; hold_req_i = 4'b0000;
    chk("t3_irqh_jen",  a_jen, 1);
    chk("t3_irqh_addr", a_addr, 32'h44);
    tick; tick; tick; tick;

    // back-to-back ex jumps; newest jump reloads the flush counter
    jump_en_i = 1'b1; jump_addr_i = 32'h280;
    tick; jump_en_i = 1'b0;
    chk("t4_b_jen1",   b_jen, 1);
    chk("t4_b_addr1",  b_addr, 32'h280);
    chk("t4_b_flush1", b_flush, 4'b0011);
    tick; jump_en_i = 1'b1; jump_addr_i = 32'h300;
    chk("t4_a_jen2",   a_jen, 0);
    chk("t4_b_jen2",   b_jen, 0);
    chk("t4_a_flush2", a_flush, 0);
    chk("t4_b_flush2", b_flush, 4'b0011);
    tick; jump_en_i = 1'b0;
    chk("t4_b_jen3",   b_jen, 1);
    chk("t4_b_addr3",  b_addr, 32'h300);
    chk("t4_a_jen3",   a_jen, 1);
    chk("t4_a_addr3",  a_addr, 32'h300);
    chk("t4_b_flush3", b_flush, 4'b0011);
    tick;
    chk("t4_b_flush4", b_flush, 4'b0011);
    chk("t4_b_jen4",   b_jen, 0);
    // stall during flush: flushed stages are not stalled
    hold_req_i = 4'b0100;
    #1 chk("t5_b_hold", b_hold, 4'b0100);
    chk("t5_b_hflag",  b_hflag, 1);
    chk("t5_a_hold",   a_hold, 4'b0111);
    tick; hold_req_i = 4'b0000;
    chk("t4_b_flush5", b_flush, 4'b0011);
    tick;
    chk("t4_b_flush6", b_flush, 0);
    tick;

    // hold timeout after 8 consecutive stalled cycles, sticky
    chk("t6_to_pre", a_to, 0);
    hold_req_i = 4'b0001;
    repeat (7) tick;
    chk("t6_to_7", a_to, 0);
    tick; hold_req_i = 4'b0000;
    chk("t6_to_8",   a_to, 1);
    chk("t6_b_to",   b_to, 0);
    tick;
    chk("t6_to_sticky", a_to, 1);

    // async reset discards flush state and a pending jump
    jump_en_i = 1'b1; jump_addr_i = 32'h500;
    tick;
    chk("t7_a_jen", a_jen, 1);
    jump_en_i = 1'b1; jump_addr_i = 32'h600; hold_req_i = 4'b1000;
    tick;
    jump_en_i = 1'b0; rst_n = 1'b0; hold_req_i = 4'b0010;
    #1 chk("t7_rst_a_jen", a_jen, 0);
    chk("t7_rst_a_addr",  a_addr, 0);
    chk("t7_rst_b_addr",  b_addr, 0);
    chk("t7_rst_b_flush", b_flush, 0);
    chk("t7_rst_a_to",    a_to, 0);
    chk("t7_rst_a_hold",  a_hold, 4'b0011);
    chk("t7_rst_a_hflag", a_hflag, 1);
    tick; rst_n = 1'b1; hold_req_i = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t7_no_pend_a", a_jen, 0);
      chk("t7_no_pend_b", b_jen, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline hazard controller: the next generation of the core's jump/hold controller. It arbitrates redirect requests from the execute stage and from the interrupt/exception unit, and registers the selected jump. It drives per-stage stall and flush vectors, defers jumps blocked by downstream holds, and flags holds that never release. It sits between the EX/MEM/interrupt units and the PC generator and pipeline registers.

## Interface
Parameters:
- ADDR_W, 32, width of jump addresses
- NUM_STAGES, 4, number of pipeline stages (stage 0 = IF, increasing downstream)
- JUMP_STAGE, 2, stage index that issues ex jumps (EX)
- FLUSH_DEPTH, 2, flush_o covers stages 0..FLUSH_DEPTH-1 (must be ≤ NUM_STAGES)
- FLUSH_CYCLES, 1, cycles flush_o stays asserted per accepted jump (≥1)
- HOLD_TIMEOUT, 1024, consecutive held cycles before timeout flag; 0 disables

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- jump_en_i  in  1  ex jump request (may be a 1-cycle pulse)
- jump_addr_i  in  ADDR_W  ex jump target
- irq_jump_en_i  in  1  interrupt/exception redirect request
- irq_jump_addr_i  in  ADDR_W  interrupt/exception target
- hold_req_i  in  NUM_STAGES  bit s = stage s requests a stall
- jump_en_o  out  1  registered one-cycle redirect pulse to PC generator
- jump_addr_o  out  ADDR_W  registered redirect target
- hold_o  out  NUM_STAGES  per-stage stall
- flush_o  out  NUM_STAGES  per-stage flush (bubble insert)
- hold_flag_o  out  1  OR of hold_o and flush_o (legacy single hold line)
- hold_timeout_o  out  1  sticky: hold persisted HOLD_TIMEOUT cycles

## Operation
- Stall mapping (combinational):
  - hold_o[i] = OR of hold_req_i[j] for j ≥ i, then masked to 0 wherever flush_o[i]=1. Flush wins over stall.
- Request selection (each cycle):
  - Candidate = irq request if irq_jump_en_i, else ex request if jump_en_i, else the pending entry.
  - A new irq request overwrites a pending entry. A new ex request overwrites a pending ex entry but never a pending irq entry.
- Blocking:
  - An ex candidate is blocked while any hold_req_i[j] with j ≥ JUMP_STAGE is 1.
  - An irq candidate is never blocked.
  - A blocked candidate is stored in the pending register (valid, addr, is_irq). Requesters need not hold the request.
- Acceptance:
  - Register jump_addr_o ← candidate addr and jump_en_o ← 1 for one cycle.
  - Clear pending.
  - FSM enters FLUSH with flush counter loaded to FLUSH_CYCLES.
- FSM states: IDLE, FLUSH.
  - IDLE→FLUSH on acceptance.
  - In FLUSH, the counter decrements each cycle. flush_o[0..FLUSH_DEPTH-1]=1 while the counter is nonzero.
  - FLUSH→IDLE when the counter reaches 1 with no new acceptance.
  - An acceptance in FLUSH reloads the counter (newest jump wins).
- Timeout:
  - A counter counts consecutive cycles with |hold_o=1 and saturates.
  - The counter clears on any cycle with |hold_o=0.
  - hold_timeout_o sets when the count reaches HOLD_TIMEOUT and stays set until reset.
  - Timeout has no effect on hold/flush behaviour.
- Reset (async, rst_n=0):
  - jump_en_o=0, jump_addr_o=0, flush_o=0, hold_timeout_o=0.
  - Pending cleared, FSM=IDLE, counters=0.
  - hold_o and hold_flag_o follow hold_req_i combinationally during reset.
  - Reset mid-FLUSH or with a pending jump discards both.

## Timing
- Accepted request at cycle N:
  - jump_en_o and jump_addr_o valid in cycle N+1 only.
  - flush_o asserted in cycles N+1..N+FLUSH_CYCLES.
- Blocked ex request at N with the blocking hold released at cycle M: accepted at M, jump_en_o at M+1.
- irq and ex requests in the same cycle: irq accepted. The ex request is dropped, not pended.
- jump_en_o is never asserted in two consecutive cycles unless two acceptances occur in consecutive cycles.
- hold_flag_o is combinational: same cycle as hold_req_i, and same cycle as flush_o.

## Test plan
- Defaults; jump_en_i=1, jump_addr_i=0x100 for one cycle at N, no holds → jump_en_o=1 and jump_addr_o=0x100 at N+1 only; flush_o=4'b0011 at N+1; 0 at N+2.
- hold_req_i=4'b1000 for 3 cycles; ex jump to 0x200 pulsed in the first of them → hold_o=4'b1111; jump deferred; jump_en_o fires exactly once, one cycle after hold_req_i drops, with addr 0x200.
- irq to 0x40 and ex to 0x80 in the same cycle → single jump_en_o with jump_addr_o=0x40; no later jump to 0x80.
- FLUSH_CYCLES=3; second ex jump to 0x300 two cycles after the first → flush_o stays 4'b0011 until 3 cycles after the second jump_en_o; jump_addr_o=0x300.
- hold_req_i=4'b0100 during flush → hold_o=4'b0100 (bits 0–1 masked by flush); hold_flag_o=1.
- HOLD_TIMEOUT=8; hold_req_i=4'b0001 held 8 cycles → hold_timeout_o=1 and stays 1 after release; rst_n pulse low mid-test → all registered outputs 0 immediately.
